// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage: FSM states and access-size encodings.
package mem_stage_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

endpackage

// File: rtl/mem_stage_dmem.sv
// Data memory for the MEM stage: asynchronous read, synchronous write with a
// byte-lane write-enable mask.
module mem_stage_dmem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                      clk,
    input  logic                      we_i,
    input  logic [(DATA_W+7)/8-1:0]   be_i,
    input  logic [ADDR_W-1:0]         addr_i,
    input  logic [DATA_W-1:0]         wdata_i,
    output logic [DATA_W-1:0]         rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mask_c;

    // Expand lane enables to a per-bit mask.
    always_comb begin
        mask_c = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            mask_c[i] = be_i[i/8];
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= (mem_q[addr_i] & ~mask_c) | (wdata_i & mask_c);
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data memory access with MEM_LAT-cycle latency and the WB
// output register. Define MEM_SUBWORD_EN for byte/half accesses (DATA_W must be 32).
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wb_en_i,
    input  logic              mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [1:0]        size_i,
    input  logic              sign_i,
    input  logic [REG_AW-1:0] dest_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] store_data_i,
    output logic              busy_o,
    output logic              wb_en_o,
    output logic [REG_AW-1:0] dest_o,
    output logic [DATA_W-1:0] result_o
);

    localparam int unsigned BE_W  = (DATA_W + 7) / 8;
    localparam int unsigned CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wb_en_q, wb_en_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic              mem_op;
    logic              commit;
    logic              mem_we;
    logic [ADDR_W-1:0] word_addr;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] ld_data;
    logic [BE_W-1:0]   be;

    assign mem_op    = mem_rd_i | mem_wr_i;
    assign word_addr = alu_result_i[ADDR_W+1:2];

`ifdef MEM_SUBWORD_EN
    logic [DATA_W-1:0] byte_sh;
    logic [DATA_W-1:0] half_sh;

    // Lane steering for stores, alignment and extension for loads.
    always_comb begin
        byte_sh = rdata >> {alu_result_i[1:0], 3'b000};
        half_sh = rdata >> {alu_result_i[1], 4'b0000};
        case (size_t'(size_i))
            SZ_BYTE: begin
                ld_data = {{(DATA_W-8){sign_i & byte_sh[7]}}, byte_sh[7:0]};
                wdata   = DATA_W'({4{store_data_i[7:0]}});
                be      = BE_W'(1) << alu_result_i[1:0];
            end
            SZ_HALF: begin
                ld_data = {{(DATA_W-16){sign_i & half_sh[15]}}, half_sh[15:0]};
                wdata   = DATA_W'({2{store_data_i[15:0]}});
                be      = alu_result_i[1] ? BE_W'(4'b1100) : BE_W'(4'b0011);
            end
            default: begin
                ld_data = rdata;
                wdata   = store_data_i;
                be      = '1;
            end
        endcase
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{size_i, sign_i};
    assign ld_data    = rdata;
    assign wdata      = store_data_i;
    assign be         = '1;
`endif

    mem_stage_dmem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dmem (
        .clk     (clk),
        .we_i    (mem_we),
        .be_i    (be),
        .addr_i  (word_addr),
        .wdata_i (wdata),
        .rdata_o (rdata)
    );

    // Stall while an access still has cycles to go; flush and reset drop it at once.
    assign busy_o = !rst && !flush &&
                    (((state_q == ST_IDLE) && mem_op && (MEM_LAT > 1)) ||
                     ((state_q == ST_WAIT) && (cnt_q != '0)));

    assign mem_we = commit && mem_wr_i && !rst;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wb_en_d  = wb_en_q;
        dest_d   = dest_q;
        result_d = result_q;
        commit   = 1'b0;

        if (flush) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            wb_en_d  = 1'b0;
            dest_d   = '0;
            result_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!mem_op) begin
                        wb_en_d  = wb_en_i;
                        dest_d   = dest_i;
                        result_d = alu_result_i;
                    end else if (MEM_LAT == 1) begin
                        commit = 1'b1;
                    end else begin
                        state_d  = ST_WAIT;
                        cnt_d    = CNT_W'(MEM_LAT - 2);
                        wb_en_d  = 1'b0;
                        dest_d   = '0;
                        result_d = '0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_d    = cnt_q - CNT_W'(1);
                        wb_en_d  = 1'b0;
                        dest_d   = '0;
                        result_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                        commit  = mem_op;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (commit) begin
                wb_en_d  = wb_en_i;
                dest_d   = dest_i;
                result_d = mem_wr_i ? alu_result_i : ld_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wb_en_q  <= 1'b0;
            dest_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wb_en_q  <= wb_en_d;
            dest_q   <= dest_d;
            result_q <= result_d;
        end
    end

    assign wb_en_o  = wb_en_q;
    assign dest_o   = dest_q;
    assign result_o = result_q;

endmodule
